// File: rtl/modport_ram_if.sv
// Bus between the RAM and its driver: write data, enables, shared address and registered read data.
interface modport_ram_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write_enb;
    logic                  read_enb;
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] data_out;

    modport master (
        output data_in,
        output write_enb,
        output read_enb,
        output address,
        input  data_out
    );

    modport slave (
        input  data_in,
        input  write_enb,
        input  read_enb,
        input  address,
        output data_out
    );
endinterface

// File: rtl/modport_ram.sv
// Single-port synchronous RAM, read-first on a shared address, registered read data.
// Synchronous reset clears the read register and every word.
module modport_ram #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic               clk,
    input  logic               reset,
    modport_ram_if.slave       bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q;

    // Read samples pre-edge contents, so a same-cycle write is seen only on the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out_q <= '0;
            mem        <= '{default: '0};
        end else begin
            if (bus.write_enb) begin
                mem[bus.address] <= bus.data_in;
            end
            if (bus.read_enb) begin
                data_out_q <= mem[bus.address];
            end
        end
    end

    assign bus.data_out = data_out_q;
endmodule

// File: tb/tb_modport_ram.sv
// Directed plus randomized checking of modport_ram against a behavioural array model.
module tb_modport_ram;
    logic clk;
    logic reset;

    modport_ram_if #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) bus ();

    modport_ram #(.DATA_WIDTH(8), .ADDR_WIDTH(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] model_mem [32];
    logic [7:0] model_out;
    int passes;
    int total;

    task automatic chk(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        total++;
        assert (observed === expected) passes++;
        else $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    endtask

    // One clock: drive on the falling edge, update model at the rising edge, compare just after.
    task automatic step(input logic rst, input logic we, input logic re,
                        input logic [4:0] addr, input logic [7:0] din);
        @(negedge clk);
        reset         = rst;
        bus.write_enb = we;
        bus.read_enb  = re;
        bus.address   = addr;
        bus.data_in   = din;
        @(posedge clk);
        if (rst) begin
            model_out = 8'h00;
            for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
        end else begin
            if (re) model_out = model_mem[addr];
            if (we) model_mem[addr] = din;
        end
        #1;
        chk("model", bus.data_out, model_out);
    endtask

    initial begin
        passes = 0;
        total  = 0;
        model_out = 8'h00;
        for (int i = 0; i < 32; i++) model_mem[i] = 8'h00;
        reset = 1'b1;
        bus.write_enb = 1'b0;
        bus.read_enb  = 1'b0;
        bus.address   = '0;
        bus.data_in   = '0;

        // Reset and reads of cleared memory
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        step(1'b1, 1'b0, 1'b0, 5'd0, 8'h00);
        chk("reset_out", bus.data_out, 8'h00);
        step(1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
        chk("rst_rd0", bus.data_out, 8'h00);
        step(1'b0, 1'b0, 1'b1, 5'd15, 8'h00);
        chk("rst_rd15", bus.data_out, 8'h00);
        step(1'b0, 1'b0, 1'b1, 5'd31, 8'h00);
        chk("rst_rd31", bus.data_out, 8'h00);

        // Write then read next cycle
        step(1'b0, 1'b1, 1'b0, 5'd3, 8'hA5);
        step(1'b0, 1'b0, 1'b1, 5'd3, 8'h00);
        chk("wr_rd3", bus.data_out, 8'hA5);

        // Address extremes
        step(1'b0, 1'b1, 1'b0, 5'd0, 8'h11);
        step(1'b0, 1'b1, 1'b0, 5'd31, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 5'd0, 8'h00);
        chk("rd_addr0", bus.data_out, 8'h11);
        step(1'b0, 1'b0, 1'b1, 5'd31, 8'h00);
        chk("rd_addr31", bus.data_out, 8'hFF);
        step(1'b0, 1'b0, 1'b1, 5'd1, 8'h00);
        chk("rd_addr1", bus.data_out, 8'h00);

        // Simultaneous write and read returns old data
        step(1'b0, 1'b1, 1'b0, 5'd7, 8'h3C);
        step(1'b0, 1'b1, 1'b1, 5'd7, 8'hC3);
        chk("rd_first", bus.data_out, 8'h3C);
        step(1'b0, 1'b0, 1'b1, 5'd7, 8'h00);
        chk("rd_after_rw", bus.data_out, 8'hC3);

        // Hold while read_enb is low
        step(1'b0, 1'b0, 1'b1, 5'd3, 8'h00);
        chk("hold_pre", bus.data_out, 8'hA5);
        step(1'b0, 1'b1, 1'b0, 5'd3, 8'h00);
        chk("hold_wr", bus.data_out, 8'hA5);
        step(1'b0, 1'b0, 1'b0, 5'd3, 8'h00);
        chk("hold_idle", bus.data_out, 8'hA5);
        step(1'b0, 1'b0, 1'b1, 5'd3, 8'h00);
        chk("hold_next_rd", bus.data_out, 8'h00);

        // Reset discards a concurrent write
        step(1'b0, 1'b1, 1'b1, 5'd9, 8'h77);
        step(1'b1, 1'b1, 1'b0, 5'd9, 8'h55);
        chk("rst_mid_out", bus.data_out, 8'h00);
        step(1'b0, 1'b0, 1'b1, 5'd9, 8'h00);
        chk("rst_mid_rd9", bus.data_out, 8'h00);
        step(1'b0, 1'b0, 1'b1, 5'd7, 8'h00);
        chk("rst_mid_rd7", bus.data_out, 8'h00);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 49) == 0),
                 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 31)),
                 8'($urandom_range(0, 255)));
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
